// File: rtl/icache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// icache_types_pkg
// Shared types and geometry for the 2-way, 8-set instruction cache controller.
//   state_e     : controller FSM states (IDLE, FILL)
//   TAG_W/IDX_W/OFF_W : address split widths (tag [31:8], index [7:5], offset [4:0])
//   NUM_WAYS    : associativity
//   way_onehot  : turns a way number into a per-way strobe vector
// ---------------------------------------------------------------------------
package icache_types_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam int TAG_W    = 24;
  localparam int IDX_W    = 3;
  localparam int OFF_W    = 5;
  localparam int NUM_WAYS = 2;

  function automatic logic [NUM_WAYS-1:0] way_onehot(input logic way);
    return way ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// ---------------------------------------------------------------------------
// icache_ctrl_if
// Bundles the CPU fetch handshake, the line-fill memory handshake and the
// per-set tag/valid/LRU array access signals of the cache controller.
//   master : controller view (drives responses, fill requests, array strobes)
//   slave  : environment view (CPU, memory and the external storage arrays)
// ---------------------------------------------------------------------------
interface icache_ctrl_if;
  import icache_types_pkg::*;

  // CPU side
  logic              cpu_read;
  logic [31:0]       cpu_addr;
  logic              cpu_resp;
  logic              way_sel;
  // Memory side
  logic              mem_read;
  logic [31:0]       mem_addr;
  logic              mem_resp;
  // Storage array side
  logic [IDX_W-1:0]  rindex;
  logic [IDX_W-1:0]  windex;
  logic [TAG_W-1:0]  tag0_out;
  logic [TAG_W-1:0]  tag1_out;
  logic              valid0_out;
  logic              valid1_out;
  logic              lru_out;
  logic [1:0]        load_tag;
  logic [1:0]        load_valid;
  logic [1:0]        load_data;
  logic              load_lru;
  logic              lru_in;

  modport master (
    input  cpu_read, cpu_addr, mem_resp,
    input  tag0_out, tag1_out, valid0_out, valid1_out, lru_out,
    output cpu_resp, way_sel, mem_read, mem_addr,
    output rindex, windex, load_tag, load_valid, load_data, load_lru, lru_in
  );

  modport slave (
    output cpu_read, cpu_addr, mem_resp,
    output tag0_out, tag1_out, valid0_out, valid1_out, lru_out,
    input  cpu_resp, way_sel, mem_read, mem_addr,
    input  rindex, windex, load_tag, load_valid, load_data, load_lru, lru_in
  );

endinterface

// File: rtl/icache_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter16
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
//   inc   in  : count one event on this rising edge
//   clk   in  : clock
//   rst   in  : synchronous active-low clear
//   count out : current count
// ---------------------------------------------------------------------------
module sat_counter16 (
  input  logic        inc,
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= 16'd0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// ---------------------------------------------------------------------------
// icache_ctrl
// Sequencing controller for a 2-way, 8-set instruction cache. The tag, valid,
// LRU and data arrays live outside; this block reads them combinationally,
// answers hits in the same cycle and runs a single-line refill on a miss.
//   clk        in  : clock
//   rst        in  : synchronous active-low reset
//   bus        mp  : icache_ctrl_if.master (CPU, memory and array signals)
//   hit_count  out : saturating count of first-time hits (refill replays excluded)
//   miss_count out : saturating count of misses
// ---------------------------------------------------------------------------
module icache_ctrl
  import icache_types_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  icache_ctrl_if.master        bus,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  state_e state_q, state_d;
  logic   victim_q, victim_d;
  logic   refill_q, refill_d;
  logic   active_q;
  logic   hit_inc, miss_inc;

  logic [TAG_W-1:0] req_tag;
  logic             hit0, hit1, victim_sel, en;
  logic             unused_offset;

  assign req_tag       = bus.cpu_addr[31:32-TAG_W];
  assign unused_offset = ^bus.cpu_addr[OFF_W-1:0];

  assign bus.rindex   = bus.cpu_addr[OFF_W+IDX_W-1:OFF_W];
  assign bus.windex   = bus.cpu_addr[OFF_W+IDX_W-1:OFF_W];
  assign bus.mem_addr = {bus.cpu_addr[31:OFF_W], {OFF_W{1'b0}}};

  assign hit0 = bus.valid0_out & (bus.tag0_out == req_tag);
  assign hit1 = bus.valid1_out & (bus.tag1_out == req_tag);

  // Fill an empty way first; only evict by LRU when the set is full.
  assign victim_sel = !bus.valid0_out ? 1'b0 :
                      !bus.valid1_out ? 1'b1 : bus.lru_out;

  // Outputs stay quiet while reset is asserted and for the first cycle after
  // it is released, so nothing reaches the arrays or memory from a
  // half-initialised controller.
  assign en = rst & active_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      refill_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      refill_q <= refill_d;
      active_q <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    victim_d       = victim_q;
    refill_d       = refill_q;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    bus.cpu_resp   = 1'b0;
    bus.way_sel    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.load_tag   = 2'b00;
    bus.load_valid = 2'b00;
    bus.load_data  = 2'b00;
    bus.load_lru   = 1'b0;
    bus.lru_in     = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && bus.cpu_read) begin
          if (hit0 || hit1) begin
            // Way 0 wins a double hit; the other way becomes LRU.
            bus.cpu_resp = 1'b1;
            bus.way_sel  = ~hit0;
            bus.load_lru = 1'b1;
            bus.lru_in   = hit0;
            // The response that completes a refill is not a genuine hit.
            hit_inc      = ~refill_q;
            refill_d     = 1'b0;
          end else begin
            victim_d = victim_sel;
            miss_inc = 1'b1;
            state_d  = FILL;
          end
        end
      end
      FILL: begin
        if (en) begin
          bus.mem_read = 1'b1;
          if (bus.mem_resp) begin
            bus.load_tag   = way_onehot(victim_q);
            bus.load_valid = way_onehot(victim_q);
            bus.load_data  = way_onehot(victim_q);
            refill_d       = 1'b1;
            state_d        = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sat_counter16 u_hit_cnt (
    .inc   (hit_inc),
    .clk   (clk),
    .rst   (rst),
    .count (hit_count)
  );

  sat_counter16 u_miss_cnt (
    .inc   (miss_inc),
    .clk   (clk),
    .rst   (rst),
    .count (miss_count)
  );

endmodule

// File: tb/tb_icache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_icache_ctrl
// Directed, table-driven bench for icache_ctrl. Models the external tag/valid/
// LRU arrays (combinational read, write on the rising edge) and checks the
// controller outputs once per cycle against hand-computed vectors, then runs
// a long hit stream to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hit_count, miss_count;

  icache_ctrl_if bus_if ();

  icache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // External array model
  logic [23:0] tag_a [2][8];
  logic        val_a [2][8];
  logic        lru_a [8];
  logic        arr_clr;
  int          wr_cnt;

  assign bus_if.tag0_out   = tag_a[0][bus_if.rindex];
  assign bus_if.tag1_out   = tag_a[1][bus_if.rindex];
  assign bus_if.valid0_out = val_a[0][bus_if.rindex];
  assign bus_if.valid1_out = val_a[1][bus_if.rindex];
  assign bus_if.lru_out    = lru_a[bus_if.rindex];

  always @(posedge clk) begin
    if (arr_clr) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 8; s++) begin
          tag_a[w][s] <= 24'd0;
          val_a[w][s] <= 1'b0;
        end
      for (int s = 0; s < 8; s++) lru_a[s] <= 1'b0;
      wr_cnt <= 0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (bus_if.load_tag[w])   tag_a[w][bus_if.windex] <= bus_if.cpu_addr[31:8];
        if (bus_if.load_valid[w]) val_a[w][bus_if.windex] <= 1'b1;
      end
      if (bus_if.load_lru) lru_a[bus_if.rindex] <= bus_if.lru_in;
      if (|bus_if.load_data) wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic        rst;
    logic        rd;
    logic [31:0] addr;
    logic        mresp;
    logic        e_resp;
    logic        e_mrd;
    logic        e_way;
    logic [1:0]  e_ld;
    logic        e_llru;
    logic        e_lruin;
    logic [15:0] e_hit;
    logic [15:0] e_miss;
  } vec_t;

  localparam int NV = 28;
  vec_t vt [NV];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] a,
                              input logic mr, input logic er, input logic em,
                              input logic ew, input logic [1:0] el, input logic ell,
                              input logic eli, input logic [15:0] eh, input logic [15:0] emi);
    vec_t v;
    v.rst = r; v.rd = rd; v.addr = a; v.mresp = mr;
    v.e_resp = er; v.e_mrd = em; v.e_way = ew; v.e_ld = el;
    v.e_llru = ell; v.e_lruin = eli; v.e_hit = eh; v.e_miss = emi;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", nm, row, act, exp);
    end
  endtask

  initial begin
    //            rst rd addr           mr  resp mrd way ld     llru lin hit miss
    vt[0]  = mk(0, 0, 32'h0000_0000, 0,  0, 0, 0, 2'b00, 0, 0, 0, 0); // in reset
    vt[1]  = mk(1, 1, 32'h0000_0120, 0,  0, 0, 0, 2'b00, 0, 0, 0, 0); // cycle after reset
    vt[2]  = mk(1, 1, 32'h0000_0120, 0,  0, 0, 0, 2'b00, 0, 0, 0, 0); // cold miss
    vt[3]  = mk(1, 1, 32'h0000_0120, 0,  0, 1, 0, 2'b00, 0, 0, 0, 1);
    vt[4]  = mk(1, 1, 32'h0000_0120, 0,  0, 1, 0, 2'b00, 0, 0, 0, 1);
    vt[5]  = mk(1, 1, 32'h0000_0120, 0,  0, 1, 0, 2'b00, 0, 0, 0, 1);
    vt[6]  = mk(1, 1, 32'h0000_0120, 1,  0, 1, 0, 2'b01, 0, 0, 0, 1); // line arrives
    vt[7]  = mk(1, 1, 32'h0000_0120, 0,  1, 0, 0, 2'b00, 1, 1, 0, 1); // refill response
    vt[8]  = mk(1, 1, 32'h0000_0124, 0,  1, 0, 0, 2'b00, 1, 1, 0, 1); // warm hit
    vt[9]  = mk(1, 0, 32'h0000_0124, 1,  0, 0, 0, 2'b00, 0, 0, 1, 1); // stray mem_resp
    vt[10] = mk(1, 1, 32'h0000_1120, 0,  0, 0, 0, 2'b00, 0, 0, 1, 1); // conflict -> way 1
    vt[11] = mk(1, 1, 32'h0000_1120, 1,  0, 1, 0, 2'b10, 0, 0, 1, 2);
    vt[12] = mk(1, 1, 32'h0000_1120, 0,  1, 0, 1, 2'b00, 1, 0, 1, 2);
    vt[13] = mk(1, 1, 32'h0000_2120, 0,  0, 0, 0, 2'b00, 0, 0, 1, 2); // set full, LRU=way0
    vt[14] = mk(1, 1, 32'h0000_2120, 0,  0, 1, 0, 2'b00, 0, 0, 1, 3);
    vt[15] = mk(1, 1, 32'h0000_2120, 1,  0, 1, 0, 2'b01, 0, 0, 1, 3);
    vt[16] = mk(1, 1, 32'h0000_2120, 0,  1, 0, 0, 2'b00, 1, 1, 1, 3);
    vt[17] = mk(1, 1, 32'h0000_1120, 0,  1, 0, 1, 2'b00, 1, 0, 1, 3); // counted hit way 1
    vt[18] = mk(1, 1, 32'h0000_0120, 0,  0, 0, 0, 2'b00, 0, 0, 2, 3); // evicted -> miss
    vt[19] = mk(1, 0, 32'h0000_0120, 0,  0, 1, 0, 2'b00, 0, 0, 2, 4); // request dropped
    vt[20] = mk(1, 0, 32'h0000_0120, 1,  0, 1, 0, 2'b01, 0, 0, 2, 4);
    vt[21] = mk(1, 0, 32'h0000_0120, 0,  0, 0, 0, 2'b00, 0, 0, 2, 4);
    vt[22] = mk(1, 0, 32'h0000_0120, 1,  0, 0, 0, 2'b00, 0, 0, 2, 4);
    vt[23] = mk(1, 1, 32'h0000_3120, 0,  0, 0, 0, 2'b00, 0, 0, 2, 4); // miss, then reset
    vt[24] = mk(1, 1, 32'h0000_3120, 0,  0, 1, 0, 2'b00, 0, 0, 2, 5);
    vt[25] = mk(0, 1, 32'h0000_3120, 0,  0, 0, 0, 2'b00, 0, 0, 2, 5);
    vt[26] = mk(1, 0, 32'h0000_3120, 1,  0, 0, 0, 2'b00, 0, 0, 0, 0); // late mem_resp
    vt[27] = mk(1, 0, 32'h0000_3120, 1,  0, 0, 0, 2'b00, 0, 0, 0, 0);

    arr_clr          = 1'b1;
    rst              = 1'b0;
    bus_if.cpu_read  = 1'b0;
    bus_if.cpu_addr  = 32'd0;
    bus_if.mem_resp  = 1'b0;
    repeat (2) @(posedge clk);
    arr_clr = 1'b0;
    #1;

    for (int i = 0; i < NV; i++) begin
      rst             = vt[i].rst;
      bus_if.cpu_read = vt[i].rd;
      bus_if.cpu_addr = vt[i].addr;
      bus_if.mem_resp = vt[i].mresp;
      #3;
      chk("cpu_resp",   i, {31'd0, bus_if.cpu_resp},  {31'd0, vt[i].e_resp});
      chk("mem_read",   i, {31'd0, bus_if.mem_read},  {31'd0, vt[i].e_mrd});
      chk("way_sel",    i, {31'd0, bus_if.way_sel},   {31'd0, vt[i].e_way});
      chk("load_data",  i, {30'd0, bus_if.load_data}, {30'd0, vt[i].e_ld});
      chk("load_tag",   i, {30'd0, bus_if.load_tag},  {30'd0, vt[i].e_ld});
      chk("load_valid", i, {30'd0, bus_if.load_valid},{30'd0, vt[i].e_ld});
      chk("load_lru",   i, {31'd0, bus_if.load_lru},  {31'd0, vt[i].e_llru});
      if (vt[i].e_llru)
        chk("lru_in",   i, {31'd0, bus_if.lru_in},    {31'd0, vt[i].e_lruin});
      if (vt[i].e_mrd)
        chk("mem_addr", i, bus_if.mem_addr, vt[i].addr & 32'hFFFF_FFE0);
      chk("rindex",     i, {29'd0, bus_if.rindex},    {29'd0, vt[i].addr[7:5]});
      chk("windex",     i, {29'd0, bus_if.windex},    {29'd0, vt[i].addr[7:5]});
      chk("hit_count",  i, {16'd0, hit_count},        {16'd0, vt[i].e_hit});
      chk("miss_count", i, {16'd0, miss_count},       {16'd0, vt[i].e_miss});
      @(posedge clk);
      #1;
    end

    // Four line fills in total; the dropped-request fill writes once and the
    // mem_resp arriving after reset writes nothing.
    chk("fill_writes", 100, wr_cnt, 32'd4);

    // Saturation: 0x120 now hits way 0 every cycle with no refill pending.
    rst             = 1'b1;
    bus_if.cpu_read = 1'b1;
    bus_if.cpu_addr = 32'h0000_0120;
    bus_if.mem_resp = 1'b0;
    #3;
    chk("sat_first_resp", 200, {31'd0, bus_if.cpu_resp}, 32'd1);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_hit_fffe",   201, {16'd0, hit_count}, 32'h0000_FFFE);
    @(posedge clk);
    #1;
    chk("sat_hit_ffff",   202, {16'd0, hit_count}, 32'h0000_FFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_hit_hold",   203, {16'd0, hit_count}, 32'h0000_FFFF);
    chk("sat_miss_zero",  204, {16'd0, miss_count}, 32'd0);
    chk("sat_resp",       205, {31'd0, bus_if.cpu_resp}, 32'd1);
    chk("sat_writes",     206, wr_cnt, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have ports (name dir width meaning): clk in 1 system clock; all state changes on rising edge.
REQ-002 SHALL have: rst in 1 reset; one clock domain, synchronous, active-low (rst=0 resets at next rising clk edge).
REQ-003 SHALL have: cpu_read in 1 fetch request; cpu_addr in 32 fetch address, held stable until cpu_resp; cpu_resp out 1 one-cycle completion.
REQ-004 SHALL have: way_sel out 1 data way the datapath muxes out (valid when cpu_resp=1).
REQ-005 SHALL have: mem_read out 1 line-fill request; mem_addr out 32 line-aligned address, {cpu_addr[31:5],5'b0}; mem_resp in 1 line data valid on mem_rdata path.
REQ-006 SHALL have: rindex out 3 and windex out 3, both cpu_addr[7:5]; tag0_out/tag1_out in 24 each; valid0_out/valid1_out in 1 each; lru_out in 1, from the per-set storage arrays.
REQ-007 SHALL have: load_tag out 2, load_valid out 2, load_data out 2 (bit n = way n); load_lru out 1; lru_in out 1.
REQ-008 SHALL have: hit_count out 16 and miss_count out 16 saturating statistics.

Function
REQ-009 Address split SHALL be tag=[31:8] (24b), index=[7:5] (3b), offset=[4:0]; 2 ways x 8 sets.
REQ-010 hitN SHALL be validN_out & (tagN_out == cpu_addr[31:8]); both hit -> way 0 wins.
REQ-011 FSM states SHALL be IDLE and FILL; reset state IDLE.
REQ-012 IDLE, cpu_read=1, hit: cpu_resp=1 same cycle (zero-wait, arrays read combinationally), way_sel=hit way, load_lru=1, lru_in=~hit way; stay IDLE.
REQ-013 IDLE, cpu_read=1, miss: no cpu_resp; latch victim way; next state FILL; miss_count +1 this edge.
REQ-014 Victim SHALL be: way 0 if valid0_out=0, else way 1 if valid1_out=0, else lru_out.
REQ-015 FILL: mem_read=1 every cycle until and including the mem_resp=1 cycle; mem_addr constant.
REQ-016 FILL with mem_resp=1: load_data, load_tag, load_valid asserted for victim bit only, one cycle; next state IDLE; set refill flag.
REQ-017 Following IDLE cycle SHALL hit via array write bypass/stored data and respond; miss latency = mem latency + 2 cycles.
REQ-018 hit_count SHALL increment on a hit response only when refill flag=0; refill flag clears on any cpu_resp.
REQ-019 Counters SHALL saturate at 16'hFFFF (no wrap); hit and miss never count in same cycle.
REQ-020 cpu_read dropped during FILL: fill SHALL complete normally; no abort, no cpu_resp if cpu_read=0 afterwards.
REQ-021 IDLE with cpu_read=0: all load_*, cpu_resp, mem_read SHALL be 0; mem_resp in IDLE SHALL be ignored.
REQ-022 All load_* SHALL be zero except in REQ-012/REQ-016 cycles; at most one way bit set.

Reset
REQ-023 rst=0 SHALL force next state IDLE, refill flag 0, victim 0, hit_count=miss_count=0.
REQ-024 During and one cycle after reset: cpu_resp, mem_read, all load_* SHALL be 0; way_sel 0.
REQ-025 Reset mid-FILL SHALL drop mem_read next cycle; a late mem_resp SHALL cause no array write.

Structure
REQ-026 Package icache_types_pkg SHALL hold state enum (IDLE, FILL), TAG_W=24, IDX_W=3, OFF_W=5, NUM_WAYS=2.
REQ-027 One sub-module SHALL exist: sat_counter16 (inc, clk, rst, count), instantiated for hit and miss counts.
REQ-028 No storage arrays inside icache_ctrl; it only sequences external per-set arrays.

Verification
REQ-029 Cold miss: reset, cpu_read addr 0x0000_0120 -> mem_read, mem_addr 0x0000_0120, mem_resp after 4 cycles -> load_*=2'b01, cpu_resp next cycle, miss_count=1, hit_count=0.
REQ-030 Warm hit: repeat 0x0000_0124 -> cpu_resp same cycle, way_sel=0, lru_in=1, hit_count=1.
REQ-031 Conflict: fill 0x0000_1120 (set 1) -> way 1 used; then 0x0000_2120 -> victim = lru_out way, its tag replaced.
REQ-032 Reset mid-fill: rst=0 during FILL, then mem_resp=1 -> no load_*, mem_read=0, counters 0.
REQ-033 Saturation: force 65537 hits -> hit_count stays 16'hFFFF.
REQ-034 Drop request: cpu_read=0 during FILL -> line written once, no cpu_resp, FSM IDLE.
